uart_receiver: RTL and testbench

Asynchronous serial receiver (8N1) that turns the `uart_rx` pin into bytes for the PROM loader. It sits directly upstream of the loader state machine, which writes the low byte and then the high byte of each 16-bit instruction word. The block provides a byte-wide ready/ack handshake plus sticky framing-error and overrun flags. Bit timing comes from a clock divider; there is no oversampling voter.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_receiver.sv | 158 +++++++++++++++
 tb/tb_uart_receiver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period divisor helper.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } uart_rx_state_t;

   // Clock cycles per bit, rounded to nearest.
   function automatic int unsigned uart_divisor(input int unsigned clock_hz,
                                                input int unsigned baud);
      return (clock_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with byte ready/ack handshake and sticky framing/overrun flags.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_HZ = 6250,
   parameter int unsigned BAUD     = 781
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_ready_o,
   input  logic       rx_ack_i,
   output logic       rx_busy_o,
   output logic       rx_frame_err_o,
   output logic       rx_overrun_o
);

   localparam int unsigned DIVISOR = uart_divisor(CLOCK_HZ, BAUD);
   localparam int unsigned TickW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [TickW-1:0] TickHalf = TickW'(DIVISOR / 2 - 1);
   localparam logic [TickW-1:0] TickFull = TickW'(DIVISOR - 1);

   generate
      if (DIVISOR < 4) begin : g_bad_divisor
         $error("uart_receiver: DIVISOR must be at least 4");
      end
   endgenerate

   logic rxs;

   sync_2ff #(
      .ResetVal (1'b1)
   ) u_sync_rx (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (rx_i),
      .q_o     (rxs)
   );

   uart_rx_state_t   state_q, state_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             byte_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_q;
      ready_d   = ready_q;
      ferr_d    = ferr_q;
      ovr_d     = ovr_q;
      byte_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rxs) begin
               state_d = StStart;
               tick_d  = TickHalf;
            end
         end
         StStart: begin
            if (tick_q == '0) begin
               if (!rxs) begin
                  state_d = StData;
                  tick_d  = TickFull;
                  bit_d   = 3'd0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               tick_d = tick_q - TickW'(1);
            end
         end
         StData: begin
            if (tick_q == '0) begin
               shift_d[bit_q] = rxs;
               tick_d         = TickFull;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               tick_d = tick_q - TickW'(1);
            end
         end
         StStop: begin
            if (tick_q == '0) begin
               if (rxs) begin
                  state_d   = StIdle;
                  byte_done = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end else begin
               tick_d = tick_q - TickW'(1);
            end
         end
         StBreak: begin
            // Wait out a held-low line so it is not re-read as start bits.
            if (rxs) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (byte_done) begin
         if (!ready_q || rx_ack_i) begin
            data_d  = shift_q;
            ready_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (ready_q && rx_ack_i) begin
         ready_d = 1'b0;
      end
   end

   always_comb begin
      rx_data_o      = data_q;
      rx_ready_o     = ready_q;
      rx_busy_o      = (state_q != StIdle);
      rx_frame_err_o = ferr_q;
      rx_overrun_o   = ovr_q;
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at default parameters (8 clocks per bit).
module tb_uart_receiver;

   localparam int BitCyc   = 8;
   localparam int FrameCyc = 10 * BitCyc;
   // Drive-to-detect is 3 edges (2 sync + IDLE edge); stop sample is H + 9*DIVISOR later.
   localparam int StopEdge = 3 + BitCyc / 2 + 9 * BitCyc;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_i = 1'b1;
   logic       rx_ack_i = 1'b0;
   logic [7:0] rx_data_o;
   logic       rx_ready_o;
   logic       rx_busy_o;
   logic       rx_frame_err_o;
   logic       rx_overrun_o;

   int n_cmp = 0;
   int n_err = 0;

   logic       log_en = 1'b0;
   logic [7:0] ready_log[$];

   uart_receiver u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_i           (rx_i),
      .rx_data_o      (rx_data_o),
      .rx_ready_o     (rx_ready_o),
      .rx_ack_i       (rx_ack_i),
      .rx_busy_o      (rx_busy_o),
      .rx_frame_err_o (rx_frame_err_o),
      .rx_overrun_o   (rx_overrun_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (log_en && rx_ready_o) ready_log.push_back(rx_data_o);
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      rx_i     = 1'b1;
      rx_ack_i = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first ncyc cycles of a frame; ack_cycle >= 0 pulses ack on that cycle.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_cycle,
                             input int ncyc);
      int b;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         b = c / BitCyc;
         if (b == 0) rx_i = 1'b0;
         else if (b == 9) rx_i = stop;
         else rx_i = d[b-1];
         if (ack_cycle >= 0) rx_ack_i = (c == ack_cycle);
      end
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      rx_ack_i = 1'b1;
      @(negedge clk);
      rx_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_cmp++; if (rx_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
      n_cmp++; if (rx_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", rx_ready_o); end
      n_cmp++; if (rx_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy_o); end
      n_cmp++; if (rx_frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err_o); end
      n_cmp++; if (rx_overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", rx_overrun_o); end
      do_reset();
   endtask

   task automatic test_basic();
      logic [7:0] d = 8'hA5;
      int b;
      do_reset();
      for (int c = 0; c < FrameCyc; c++) begin
         @(negedge clk);
         b = c / BitCyc;
         rx_i = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
         @(posedge clk);
         #1;
         if (c + 1 == 2) begin
            n_cmp++; if (rx_busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_early: got %b want 0", rx_busy_o); end
         end
         if (c + 1 == 40) begin
            n_cmp++; if (rx_busy_o !== 1'b1) begin n_err++; $display("FAIL basic_busy_mid: got %b want 1", rx_busy_o); end
         end
         if (c + 1 == StopEdge - 1) begin
            n_cmp++; if (rx_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ready_early: got %b want 0", rx_ready_o); end
         end
         if (c + 1 == StopEdge) begin
            n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", rx_ready_o); end
            n_cmp++; if (rx_data_o !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", rx_data_o); end
         end
      end
      @(negedge clk);
      rx_ack_i = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (rx_ready_o !== 1'b0) begin n_err++; $display("FAIL basic_ack: got %b want 0", rx_ready_o); end
      rx_ack_i = 1'b0;
      n_cmp++; if ({rx_frame_err_o, rx_overrun_o} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b want 00", {rx_frame_err_o, rx_overrun_o}); end
   endtask

   task automatic test_glitch();
      logic saw_busy = 1'b0;
      logic saw_bad  = 1'b0;
      do_reset();
      @(negedge clk);
      rx_i = 1'b0;
      repeat (2) @(negedge clk);
      rx_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (rx_busy_o) saw_busy = 1'b1;
         if (rx_ready_o || rx_frame_err_o || rx_overrun_o) saw_bad = 1'b1;
      end
      n_cmp++; if (saw_busy !== 1'b1) begin n_err++; $display("FAIL glitch_detect: busy seen %b want 1", saw_busy); end
      n_cmp++; if (saw_bad !== 1'b0) begin n_err++; $display("FAIL glitch_quiet: ready/flag seen %b want 0", saw_bad); end
      n_cmp++; if (rx_busy_o !== 1'b0) begin n_err++; $display("FAIL glitch_idle: busy %b want 0", rx_busy_o); end
   endtask

   task automatic test_frame_err();
      do_reset();
      send_frame(8'h3C, 1'b0, -1, FrameCyc);
      idle(20);
      n_cmp++; if (rx_busy_o !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b want 1", rx_busy_o); end
      n_cmp++; if (rx_frame_err_o !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", rx_frame_err_o); end
      n_cmp++; if (rx_ready_o !== 1'b0) begin n_err++; $display("FAIL ferr_no_ready: got %b want 0", rx_ready_o); end
      rx_i = 1'b1;
      idle(10);
      n_cmp++; if (rx_busy_o !== 1'b0) begin n_err++; $display("FAIL ferr_break_exit: got %b want 0", rx_busy_o); end
      send_frame(8'h81, 1'b1, -1, FrameCyc);
      idle(3);
      n_cmp++; if (rx_data_o !== 8'h81) begin n_err++; $display("FAIL ferr_next_data: got %h want 81", rx_data_o); end
      n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL ferr_next_ready: got %b want 1", rx_ready_o); end
      n_cmp++; if (rx_frame_err_o !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", rx_frame_err_o); end
   endtask

   task automatic test_overrun();
      do_reset();
      send_frame(8'h11, 1'b1, -1, FrameCyc);
      idle(4);
      send_frame(8'h22, 1'b1, -1, FrameCyc);
      idle(4);
      n_cmp++; if (rx_data_o !== 8'h11) begin n_err++; $display("FAIL ovr_keep_data: got %h want 11", rx_data_o); end
      n_cmp++; if (rx_overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", rx_overrun_o); end
      n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL ovr_ready: got %b want 1", rx_ready_o); end
      do_reset();
      send_frame(8'h11, 1'b1, -1, FrameCyc);
      idle(4);
      // Drive cycle StopEdge-1 lands ack on the stop-sample edge.
      send_frame(8'h22, 1'b1, StopEdge - 1, FrameCyc);
      idle(4);
      n_cmp++; if (rx_data_o !== 8'h22) begin n_err++; $display("FAIL ovr_ack_data: got %h want 22", rx_data_o); end
      n_cmp++; if (rx_overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_ack_noflag: got %b want 0", rx_overrun_o); end
      n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL ovr_ack_ready: got %b want 1", rx_ready_o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$] = '{8'h00, 8'hFF, 8'h5A};
      do_reset();
      ready_log.delete();
      @(negedge clk);
      rx_ack_i = 1'b1;
      log_en   = 1'b1;
      foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, -1, FrameCyc);
      idle(10);
      log_en   = 1'b0;
      rx_ack_i = 1'b0;
      n_cmp++; if (ready_log.size() !== 3) begin n_err++; $display("FAIL b2b_pulses: got %0d want 3", ready_log.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < ready_log.size()) begin
            n_cmp++; if (ready_log[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, ready_log[i], exp_q[i]); end
         end
      end
      n_cmp++; if ({rx_frame_err_o, rx_overrun_o} !== 2'b00) begin n_err++; $display("FAIL b2b_flags: got %b want 00", {rx_frame_err_o, rx_overrun_o}); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      send_frame(8'h55, 1'b1, -1, FrameCyc);
      idle(3);
      // Stop partway through data bit 4 of 0xC3.
      send_frame(8'hC3, 1'b1, -1, 5 * BitCyc + 4);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_cmp++; if (rx_data_o !== 8'h00) begin n_err++; $display("FAIL mrst_data: got %h want 00", rx_data_o); end
      n_cmp++; if (rx_ready_o !== 1'b0) begin n_err++; $display("FAIL mrst_ready: got %b want 0", rx_ready_o); end
      n_cmp++; if (rx_busy_o !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b want 0", rx_busy_o); end
      rx_i = 1'b1;
      idle(3);
      reset_n = 1'b1;
      idle(5);
      send_frame(8'h7E, 1'b1, -1, FrameCyc);
      idle(3);
      n_cmp++; if (rx_data_o !== 8'h7E) begin n_err++; $display("FAIL mrst_next_data: got %h want 7e", rx_data_o); end
      n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL mrst_next_ready: got %b want 1", rx_ready_o); end
      n_cmp++; if ({rx_frame_err_o, rx_overrun_o} !== 2'b00) begin n_err++; $display("FAIL mrst_flags: got %b want 00", {rx_frame_err_o, rx_overrun_o}); end
   endtask

   // Random frames against a byte-level model of the handshake and sticky flags.
   task automatic test_random();
      logic [7:0] exp_data = 8'h00;
      logic       exp_ready = 1'b0;
      logic       exp_ferr = 1'b0;
      logic       exp_ovr = 1'b0;
      logic [7:0] d;
      logic       good;
      do_reset();
      for (int n = 0; n < 12; n++) begin
         d    = 8'($urandom);
         good = ($urandom_range(0, 4) != 0);
         send_frame(d, good, -1, FrameCyc);
         if (!good) begin
            idle($urandom_range(0, 15));
            rx_i = 1'b1;
            exp_ferr = 1'b1;
         end else if (!exp_ready) begin
            exp_data  = d;
            exp_ready = 1'b1;
         end else begin
            exp_ovr = 1'b1;
         end
         idle($urandom_range(3, 12));
         n_cmp++; if (rx_data_o !== exp_data) begin n_err++; $display("FAIL rand%0d_data: got %h want %h", n, rx_data_o, exp_data); end
         n_cmp++; if (rx_ready_o !== exp_ready) begin n_err++; $display("FAIL rand%0d_ready: got %b want %b", n, rx_ready_o, exp_ready); end
         n_cmp++; if (rx_frame_err_o !== exp_ferr) begin n_err++; $display("FAIL rand%0d_ferr: got %b want %b", n, rx_frame_err_o, exp_ferr); end
         n_cmp++; if (rx_overrun_o !== exp_ovr) begin n_err++; $display("FAIL rand%0d_ovr: got %b want %b", n, rx_overrun_o, exp_ovr); end
         if ($urandom_range(0, 1) == 1) begin
            ack_pulse();
            exp_ready = 1'b0;
            n_cmp++; if (rx_ready_o !== exp_ready) begin n_err++; $display("FAIL rand%0d_ack: got %b want 0", n, rx_ready_o); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
